// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared RV32 fetch constants, fetch entry type and helpers
package rv32_pkg;

  localparam logic [31:0] RV32_NOP      = 32'h0000_0013;
  localparam logic [31:0] RV32_HALT     = 32'hFFFF_FFFF;
  localparam logic [31:0] RV32_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/rv32_fetch_queue_if.sv
// rtl/rv32_fetch_queue_if.sv - IF stage bus bundle: imem read port, IF/ID code bus, redirect
// master: fetch front end (drives imem_req/imem_addr, code_bus/code_pc/code_valid, halted)
// slave : surrounding core (drives imem_rdata, id_ready, redirect/redirect_pc)
interface rv32_fetch_queue_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] code_bus;
  logic [31:0] code_pc;
  logic        code_valid;
  logic        id_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halted;

  modport master (
    output imem_req, imem_addr, code_bus, code_pc, code_valid, halted,
    input  imem_rdata, id_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, code_bus, code_pc, code_valid, halted,
    output imem_rdata, id_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/rv32_sync_fifo.sv
// rtl/rv32_sync_fifo.sv - power-of-two synchronous FIFO with wrap-around pointers and clear
// Ports: clk, rst_n (async low), clear (sync flush, wins over push/pop),
//        push/push_data, pop, head_data (current head), count, empty.
module rv32_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head_data = mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: contents are only observed through a non-empty count.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wptr] <= push_data;
  end

endmodule

// File: rtl/rv32_fetch_queue.sv
// rtl/rv32_fetch_queue.sv - RV32 instruction fetch front end with decode-side queue
// Ports: clk, rst_n (async low), bus (rv32_fetch_queue_if.master):
//   imem_req/imem_addr/imem_rdata : 1-cycle-latency instruction memory read
//   code_bus/code_pc/code_valid/id_ready : IF/ID handoff (NOP and pc 0 when empty)
//   redirect/redirect_pc : flush and restart fetch; halted : halt word enqueued
module rv32_fetch_queue
  import rv32_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RV32_RESET_PC
) (
  input  logic                clk,
  input  logic                rst_n,
  rv32_fetch_queue_if.master  bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   fetch_pc;
  logic [31:0]   inflight_pc;
  logic          inflight;
  logic          drop;
  logic          halt_seen;
  logic          run;
  logic [CW-1:0] count;
  logic [CW:0]   occupancy;
  logic          empty;
  logic          issue;
  logic          push;
  logic          pop;
  fetch_entry_t  head;
  fetch_entry_t  push_entry;

  // Counting the outstanding read against capacity means a response always has a slot.
  assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign issue     = run && !bus.redirect && !halt_seen && (occupancy < (CW+1)'(DEPTH));
  assign push      = inflight && !drop && !bus.redirect;
  assign pop       = !empty && bus.id_ready && !bus.redirect;

  assign push_entry = '{instr: bus.imem_rdata, pc: inflight_pc};

  assign bus.imem_req   = issue;
  assign bus.imem_addr  = fetch_pc;
  assign bus.code_valid = !empty;
  assign bus.code_bus   = empty ? RV32_NOP : head.instr;
  assign bus.code_pc    = empty ? 32'h0 : head.pc;
  assign bus.halted     = halt_seen;

  rv32_sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (bus.redirect),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head_data (head),
    .count     (count),
    .empty     (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= word_align(RESET_PC);
      inflight_pc <= word_align(RESET_PC);
      inflight    <= 1'b0;
      drop        <= 1'b0;
      halt_seen   <= 1'b0;
      run         <= 1'b0;
    end else begin
      // run holds off the first request until the first edge after reset release.
      run  <= 1'b1;
      // Guards the cycle after a flush so nothing issued before it can land.
      drop <= bus.redirect;
      if (bus.redirect) begin
        fetch_pc  <= word_align(bus.redirect_pc);
        inflight  <= 1'b0;
        halt_seen <= 1'b0;
      end else begin
        inflight <= issue;
        if (issue) begin
          fetch_pc    <= fetch_pc + 32'd4;
          inflight_pc <= fetch_pc;
        end
        if (push && (bus.imem_rdata == RV32_HALT)) halt_seen <= 1'b1;
      end
    end
  end

endmodule

// File: doc/rv32_fetch_queue.md
# rv32_fetch_queue

Instruction-fetch front end for the 5-stage RV32 core: maintains the fetch PC, issues reads to the instruction memory, and buffers returned words in a small queue. It is the producer side of the IF/ID `code_bus` interface that the decode stage consumes. It absorbs decode stalls, flushes on PC redirects from branch/jump resolution, and stops fetching after the halt word `32'hFFFF_FFFF`.

## Interface
Parameters:
- `DEPTH`, 4 — queue entries; power of two, ≥2.
- `RESET_PC`, `32'h0000_0000` — first fetch address after reset.

Ports:
- `clk` in 1 — single clock; all state on rising edge.
- `rst_n` in 1 — asynchronous, active-low reset.
- `imem_req` out 1 — read strobe to instruction memory.
- `imem_addr` out 32 — word-aligned read address; `[1:0]` always 0.
- `imem_rdata` in 32 — read data; valid exactly 1 cycle after `imem_req`.
- `code_bus` out 32 — instruction to decode; NOP `32'h0000_0013` when the queue is empty.
- `code_pc` out 32 — address of `code_bus`; 0 when the queue is empty.
- `code_valid` out 1 — queue head valid.
- `id_ready` in 1 — decode accepts head this cycle (low = stall).
- `redirect` in 1 — flush and restart fetch.
- `redirect_pc` in 32 — new fetch address; `[1:0]` ignored (forced 0).
- `halted` out 1 — halt word has been enqueued; fetch stopped.

## Operation
- State: `fetch_pc` (32), `inflight` (1 bit, plus its PC), `drop` flag, queue of {instr, pc}, `halt_seen`.
- Reset values: `fetch_pc=RESET_PC`, queue empty, `inflight=0`, `drop=0`, `halt_seen=0`; outputs `imem_req=0`, `imem_addr=RESET_PC`, `code_valid=0`, `code_bus=NOP`, `code_pc=0`, `halted=0`.
- Issue: `imem_req=1` when `!redirect && !halt_seen && (count + inflight) < DEPTH`. `imem_addr=fetch_pc`; on issue `fetch_pc += 4` (wraps mod 2^32), `inflight<=1`.
- Return: the cycle after an issue, `imem_rdata` and the issued PC are pushed unless `drop` or `redirect` is set. The occupancy rule guarantees the push never overflows.
- Pop: `code_valid && id_ready && !redirect` removes the head. Push and pop in the same cycle are both honoured, so count is unchanged.
- Halt: pushing `32'hFFFF_FFFF` sets `halt_seen`, and no further requests issue. The halt word itself is still delivered to decode. `halted = halt_seen`.
- Redirect (highest priority):
  - Queue cleared.
  - `fetch_pc <= {redirect_pc[31:2],2'b00}`.
  - `halt_seen` cleared.
  - No `imem_req` in the redirect cycle.
  - An in-flight response arriving in the redirect cycle is discarded.
  - A response to a request issued in the redirect cycle cannot occur, because none is issued.
- Back-to-back redirects: the last one wins. Redirect while halted resumes fetch.
- Reset mid-operation clears everything immediately (asynchronous); in-flight data after reset release is ignored (`inflight=0`).

## Timing
- Throughput: 1 instruction/cycle sustained while `id_ready=1`. Occupancy never exceeds `DEPTH`.
- Reset release at edge E0: `imem_req=1`, `addr=RESET_PC` in cycle 1. Data pushed at end of cycle 2; `code_valid=1` in cycle 3.
- Latency from issue to `code_valid`: 2 cycles.
- Redirect asserted in cycle R:
  - `code_valid=0` in R+1.
  - `imem_req` to the target in R+1.
  - Target instruction on `code_bus` in R+3.
- Stall: with `id_ready=0`, head and `code_pc` hold stable. Fetch continues until `count + inflight = DEPTH`, then `imem_req=0`.
- Empty queue: `code_valid=0`, `code_bus=NOP`, same cycle the last entry pops.

## Structure
- Shared package `rv32_pkg`: `RV32_NOP = 32'h0000_0013`, `RV32_HALT = 32'hFFFF_FFFF`, `RV32_RESET_PC`, and a struct `fetch_entry_t` {instr[31:0], pc[31:0]}.
- One sub-module, `rv32_sync_fifo`, parameterised on width/depth. It uses wrap-around read/write pointers, a count, and a synchronous clear. `rv32_fetch_queue` holds the PC, in-flight, drop and halt control.

## Test plan
- Reset, `RESET_PC=0`, memory word `i` = `0x00100093 + (i<<20)`, `id_ready=1` → `code_pc` 0,4,8,… on consecutive cycles starting cycle 3, with matching `code_bus`.
- Hold `id_ready=0` for 10 cycles after the first valid → at most 4 entries held, `imem_req=0` once full, head unchanged. Release → order preserved, no gaps or duplicates.
- `redirect=1`, `redirect_pc=0x103` while the queue has 3 entries and a request is in flight → `code_valid=0` next cycle, `imem_addr=0x100`, first `code_pc=0x100` two cycles later, no stale words delivered.
- Word at `0x10` = `0xFFFFFFFF` → delivered to decode, `halted=1`, no `imem_req` after the cycle it is pushed. A later `redirect` to `0x40` resumes fetch and `halted=0`.
- `rst_n` pulsed low mid-stream with the queue full → all outputs at reset values asynchronously; fetch restarts at `RESET_PC`.
- Redirect and `id_ready` in the same cycle, with the queue at `DEPTH` → no pop, queue empty, no overflow or underflow.
